mcs_wb_bridge: RTL and testbench
================================

MCS_WB_BRIDGE -- requirements
Module: mcs_wb_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: IO bus and Wishbone address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting for ACK (1..65535).
REQ-004 SHALL have port CLK, input, 1: single clock.
REQ-005 SHALL have port RST, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port IO_addr_strobe, input, 1: MCS transfer start.
REQ-007 SHALL have port IO_read_strobe, input, 1: read request, qualified by IO_addr_strobe.
REQ-008 SHALL have port IO_write_strobe, input, 1: write request, qualified by IO_addr_strobe.
REQ-009 SHALL have port IO_address, input, ADDR_WIDTH: transfer address.
REQ-010 SHALL have port IO_write_data, input, DATA_WIDTH: write data.
REQ-011 SHALL have port IO_read_data, output, DATA_WIDTH: read data, valid while IO_ready=1.
REQ-012 SHALL have port IO_ready, output, 1: one-cycle transfer-complete pulse.
REQ-013 SHALL have ports CYC, STB, WE, outputs, 1 each: Wishbone master controls.
REQ-014 SHALL have ports ADDR (output, ADDR_WIDTH) and DAT_O (output, DATA_WIDTH): address and write data toward the MMIO controller.
REQ-015 SHALL have ports DAT_I (input, DATA_WIDTH) and ACK (input, 1): slave response.
REQ-016 SHALL have port timeout_flag, output, 1: sticky bus-timeout indicator.
REQ-017 SHALL have port timeout_clr, input, 1: clears timeout_flag.

Function
REQ-018 SHALL implement FSM with states IDLE, BUS, RESP.
REQ-019 In IDLE, when IO_addr_strobe=1 and (IO_read_strobe|IO_write_strobe)=1 in cycle N, SHALL register IO_address->ADDR, IO_write_data->DAT_O and IO_write_strobe->WE, and enter BUS with CYC=STB=1 from cycle N+1.
REQ-020 When IO_read_strobe and IO_write_strobe are both 1, SHALL perform a write.
REQ-021 SHALL ignore IO_addr_strobe when neither read nor write strobe is set, and SHALL ignore every strobe outside IDLE (no queuing).
REQ-022 In BUS, SHALL hold CYC, STB, WE, ADDR and DAT_O stable until ACK or timeout.
REQ-023 On ACK=1 in cycle M, SHALL capture DAT_I on reads, deassert CYC/STB from M+1, and drive IO_ready=1 during M+1 (state RESP).
REQ-024 Minimum strobe-to-IO_ready latency SHALL be 2 cycles, reached when ACK arrives in the first BUS cycle.
REQ-025 SHALL count BUS cycles with a 16-bit counter cleared on BUS entry; if the count reaches TIMEOUT without ACK, SHALL end the cycle as in REQ-023, return 32'hDEAD_BEEF on reads, and set timeout_flag.
REQ-026 ACK in the same cycle the counter reaches TIMEOUT SHALL count as a normal completion: no timeout, real DAT_I returned.
REQ-027 ACK seen outside BUS SHALL be ignored.
REQ-028 RESP SHALL last exactly one cycle, then return to IDLE; a new transfer can start in the following cycle.
REQ-029 IO_read_data SHALL hold the last returned read value between transfers and SHALL be unchanged by writes.
REQ-030 timeout_flag SHALL stay set until timeout_clr=1; a new timeout in the same cycle as timeout_clr SHALL win (flag stays 1).

Reset
REQ-031 Reset low SHALL force IDLE asynchronously, including mid-transfer, and SHALL clear: CYC=STB=WE=0, ADDR=0, DAT_O=0, IO_ready=0, IO_read_data=0, timeout_flag=0, counter=0.
REQ-032 After reset release, SHALL accept a strobe in the first clock edge.

Verification
REQ-033 Write: strobe, address 0x0000_0C08, data 0x0000_00A5, write strobe set; ACK on the 2nd BUS cycle -> CYC/STB/WE high for 2 cycles, DAT_O=0xA5, IO_ready pulse in the 3rd cycle after the strobe.
REQ-034 Read: address 0x0000_0C00, ACK in the 1st BUS cycle with DAT_I=0x1234_5678 -> IO_ready at N+2 with IO_read_data=0x1234_5678.
REQ-035 Timeout: TIMEOUT=4, read with ACK never asserted -> CYC drops after 4 BUS cycles, IO_read_data=0xDEAD_BEEF, timeout_flag=1; timeout_clr pulse -> flag 0.
REQ-036 ACK on the exact TIMEOUT cycle with DAT_I=0x55 -> IO_read_data=0x55, timeout_flag stays 0.
REQ-037 RST low during BUS -> CYC/STB drop with no clock edge, no IO_ready; next strobe after release completes normally.
REQ-038 Strobe during BUS, and both read and write strobes set together -> the extra strobe produces no second cycle; the combined request is issued as WE=1.

Source files
------------

// File: rtl/mcs_wb_bridge.sv
// MicroBlaze MCS IO bus to Wishbone classic master bridge.
// One outstanding transfer; a bus watchdog ends stalled cycles and latches a sticky flag.
module mcs_wb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IO_addr_strobe,
    input  logic                  IO_read_strobe,
    input  logic                  IO_write_strobe,
    input  logic [ADDR_WIDTH-1:0] IO_address,
    input  logic [DATA_WIDTH-1:0] IO_write_data,
    output logic [DATA_WIDTH-1:0] IO_read_data,
    output logic                  IO_ready,
    output logic                  CYC,
    output logic                  STB,
    output logic                  WE,
    output logic [ADDR_WIDTH-1:0] ADDR,
    output logic [DATA_WIDTH-1:0] DAT_O,
    input  logic [DATA_WIDTH-1:0] DAT_I,
    input  logic                  ACK,
    output logic                  timeout_flag,
    input  logic                  timeout_clr
);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    localparam logic [15:0]           TO_CNT  = 16'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] TO_DATA = DATA_WIDTH'(32'hDEAD_BEEF);

    state_t      state;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        req_valid;
    logic        expired;
    req_t        req;

    // Both strobes together resolve to a write.
    assign req_valid = IO_addr_strobe & (IO_read_strobe | IO_write_strobe);
    assign req.we    = IO_write_strobe;
    assign req.addr  = IO_address;
    assign req.data  = IO_write_data;

    // Count includes the current BUS cycle, so BUS lasts at most TIMEOUT cycles.
    assign cnt_nxt = cnt + 16'd1;
    assign expired = (cnt_nxt == TO_CNT);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            cnt          <= '0;
            CYC          <= 1'b0;
            STB          <= 1'b0;
            WE           <= 1'b0;
            ADDR         <= '0;
            DAT_O        <= '0;
            IO_ready     <= 1'b0;
            IO_read_data <= '0;
            timeout_flag <= 1'b0;
        end else begin
            IO_ready <= 1'b0;
            if (timeout_clr)
                timeout_flag <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ADDR  <= req.addr;
                        DAT_O <= req.data;
                        WE    <= req.we;
                        CYC   <= 1'b1;
                        STB   <= 1'b1;
                        cnt   <= '0;
                        state <= BUS;
                    end
                end

                BUS: begin
                    cnt <= cnt_nxt;
                    if (ACK) begin
                        CYC      <= 1'b0;
                        STB      <= 1'b0;
                        WE       <= 1'b0;
                        IO_ready <= 1'b1;
                        if (!WE)
                            IO_read_data <= DAT_I;
                        state <= RESP;
                    end else if (expired) begin
                        CYC          <= 1'b0;
                        STB          <= 1'b0;
                        WE           <= 1'b0;
                        IO_ready     <= 1'b1;
                        // Placed after the clear so a coincident timeout keeps the flag set.
                        timeout_flag <= 1'b1;
                        if (!WE)
                            IO_read_data <= TO_DATA;
                        state <= RESP;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcs_wb_bridge.sv
// Directed self-checking bench for mcs_wb_bridge with TIMEOUT=4.
module tb_mcs_wb_bridge;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IO_addr_strobe, IO_read_strobe, IO_write_strobe;
    logic [31:0] IO_address, IO_write_data, IO_read_data;
    logic        IO_ready, CYC, STB, WE;
    logic [31:0] ADDR, DAT_O, DAT_I;
    logic        ACK, timeout_flag, timeout_clr;

    int checks = 0;
    int errors = 0;

    mcs_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .CLK(CLK), .RST(RST),
        .IO_addr_strobe(IO_addr_strobe), .IO_read_strobe(IO_read_strobe),
        .IO_write_strobe(IO_write_strobe), .IO_address(IO_address),
        .IO_write_data(IO_write_data), .IO_read_data(IO_read_data),
        .IO_ready(IO_ready), .CYC(CYC), .STB(STB), .WE(WE),
        .ADDR(ADDR), .DAT_O(DAT_O), .DAT_I(DAT_I), .ACK(ACK),
        .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic strobe(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        IO_addr_strobe  = 1'b1;
        IO_read_strobe  = rd;
        IO_write_strobe = wr;
        IO_address      = a;
        IO_write_data   = d;
    endtask

    task automatic unstrobe();
        IO_addr_strobe  = 1'b0;
        IO_read_strobe  = 1'b0;
        IO_write_strobe = 1'b0;
    endtask

    initial begin
        RST = 1'b0; ACK = 1'b0; DAT_I = '0; timeout_clr = 1'b0;
        IO_address = '0; IO_write_data = '0;
        unstrobe();

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_cyc", 32'(CYC), 32'd0);
        chk("rst_stb", 32'(STB), 32'd0);
        chk("rst_we", 32'(WE), 32'd0);
        chk("rst_addr", ADDR, 32'd0);
        chk("rst_dato", DAT_O, 32'd0);
        chk("rst_ready", 32'(IO_ready), 32'd0);
        chk("rst_rdata", IO_read_data, 32'd0);
        chk("rst_tflag", 32'(timeout_flag), 32'd0);

        // Write, strobe on the first edge after release, ACK on 2nd BUS cycle
        RST = 1'b1;
        strobe(1'b0, 1'b1, 32'h0000_0C08, 32'h0000_00A5);
        cyc();
        unstrobe();
        chk("wr_b1_cyc", 32'(CYC), 32'd1);
        chk("wr_b1_stb", 32'(STB), 32'd1);
        chk("wr_b1_we", 32'(WE), 32'd1);
        chk("wr_b1_addr", ADDR, 32'h0000_0C08);
        chk("wr_b1_dato", DAT_O, 32'h0000_00A5);
        chk("wr_b1_ready", 32'(IO_ready), 32'd0);
        cyc();
        chk("wr_b2_cyc", 32'(CYC), 32'd1);
        chk("wr_b2_we", 32'(WE), 32'd1);
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        chk("wr_resp_ready", 32'(IO_ready), 32'd1);
        chk("wr_resp_cyc", 32'(CYC), 32'd0);
        chk("wr_resp_stb", 32'(STB), 32'd0);
        chk("wr_rdata_kept", IO_read_data, 32'd0);
        cyc();
        chk("wr_ready_pulse", 32'(IO_ready), 32'd0);

        // Read, ACK in first BUS cycle: IO_ready at N+2
        strobe(1'b1, 1'b0, 32'h0000_0C00, 32'h0);
        cyc();
        unstrobe();
        chk("rd_b1_cyc", 32'(CYC), 32'd1);
        chk("rd_b1_we", 32'(WE), 32'd0);
        chk("rd_b1_addr", ADDR, 32'h0000_0C00);
        ACK = 1'b1; DAT_I = 32'h1234_5678;
        cyc();
        chk("rd_ready", 32'(IO_ready), 32'd1);
        chk("rd_data", IO_read_data, 32'h1234_5678);
        chk("rd_cyc_off", 32'(CYC), 32'd0);
        // ACK held high in RESP and IDLE is ignored
        DAT_I = 32'h9999_9999;
        cyc();
        chk("ack_resp_ready", 32'(IO_ready), 32'd0);
        cyc();
        ACK = 1'b0;
        chk("ack_idle_cyc", 32'(CYC), 32'd0);
        chk("ack_idle_ready", 32'(IO_ready), 32'd0);
        chk("ack_idle_rdata", IO_read_data, 32'h1234_5678);

        // Address strobe without read/write is ignored
        strobe(1'b0, 1'b0, 32'h0000_0100, 32'h0);
        cyc();
        unstrobe();
        chk("nostrobe_cyc", 32'(CYC), 32'd0);

        // Timeout: 4 BUS cycles, then DEAD_BEEF and sticky flag
        strobe(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        cyc();
        unstrobe();
        chk("to_b1_cyc", 32'(CYC), 32'd1);
        cyc();
        cyc();
        cyc();
        chk("to_b4_cyc", 32'(CYC), 32'd1);
        chk("to_b4_flag", 32'(timeout_flag), 32'd0);
        cyc();
        chk("to_cyc_off", 32'(CYC), 32'd0);
        chk("to_ready", 32'(IO_ready), 32'd1);
        chk("to_rdata", IO_read_data, 32'hDEAD_BEEF);
        chk("to_flag", 32'(timeout_flag), 32'd1);
        cyc();
        cyc();
        chk("to_flag_sticky", 32'(timeout_flag), 32'd1);

        // Second timeout with clear on the same edge: set wins
        strobe(1'b1, 1'b0, 32'h0000_0014, 32'h0);
        cyc();
        unstrobe();
        cyc();
        cyc();
        cyc();
        timeout_clr = 1'b1;
        cyc();
        timeout_clr = 1'b0;
        chk("to_clr_race_ready", 32'(IO_ready), 32'd1);
        chk("to_clr_race_flag", 32'(timeout_flag), 32'd1);
        timeout_clr = 1'b1;
        cyc();
        timeout_clr = 1'b0;
        chk("to_clr_flag", 32'(timeout_flag), 32'd0);

        // ACK on the exact timeout cycle is a normal completion
        strobe(1'b1, 1'b0, 32'h0000_0018, 32'h0);
        cyc();
        unstrobe();
        cyc();
        cyc();
        cyc();
        ACK = 1'b1; DAT_I = 32'h0000_0055;
        cyc();
        ACK = 1'b0;
        chk("edge_ready", 32'(IO_ready), 32'd1);
        chk("edge_rdata", IO_read_data, 32'h0000_0055);
        chk("edge_flag", 32'(timeout_flag), 32'd0);
        cyc();

        // Asynchronous reset mid-BUS
        strobe(1'b0, 1'b1, 32'h0000_0020, 32'h0000_00EE);
        cyc();
        unstrobe();
        chk("ar_bus_cyc", 32'(CYC), 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("ar_cyc", 32'(CYC), 32'd0);
        chk("ar_stb", 32'(STB), 32'd0);
        chk("ar_addr", ADDR, 32'd0);
        chk("ar_rdata", IO_read_data, 32'd0);
        @(negedge CLK);
        chk("ar_ready", 32'(IO_ready), 32'd0);
        RST = 1'b1;
        strobe(1'b1, 1'b0, 32'h0000_0024, 32'h0);
        cyc();
        unstrobe();
        chk("ar_next_cyc", 32'(CYC), 32'd1);
        ACK = 1'b1; DAT_I = 32'hCAFE_F00D;
        cyc();
        ACK = 1'b0;
        chk("ar_next_ready", 32'(IO_ready), 32'd1);
        chk("ar_next_rdata", IO_read_data, 32'hCAFE_F00D);
        cyc();

        // Read+write together is a write; strobes during BUS/RESP are dropped
        strobe(1'b1, 1'b1, 32'h0000_0030, 32'h0000_0077);
        cyc();
        chk("rw_we", 32'(WE), 32'd1);
        chk("rw_dato", DAT_O, 32'h0000_0077);
        strobe(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        cyc();
        unstrobe();
        chk("busstb_addr", ADDR, 32'h0000_0030);
        chk("busstb_we", 32'(WE), 32'd1);
        ACK = 1'b1;
        cyc();
        ACK = 1'b0;
        chk("rw_ready", 32'(IO_ready), 32'd1);
        chk("rw_rdata_kept", IO_read_data, 32'hCAFE_F00D);
        strobe(1'b1, 1'b0, 32'h0000_0044, 32'h0);
        cyc();
        unstrobe();
        chk("respstb_cyc", 32'(CYC), 32'd0);
        chk("respstb_ready", 32'(IO_ready), 32'd0);
        cyc();
        chk("no_second_cyc", 32'(CYC), 32'd0);
        chk("no_second_ready", 32'(IO_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
